// File: rtl/lfsr_3bits_checker_if.sv
// Bundles the sample stream from the generator side together with the
// lock/error status returned by the checker.
interface lfsr_3bits_checker_if #(
    parameter int COUNT_W = 8
);
    logic [2:0]         seed;
    logic               in_valid;
    logic [2:0]         in_data;
    logic               locked;
    logic               mismatch;
    logic [COUNT_W-1:0] err_count;

    modport master (
        output seed,
        output in_valid,
        output in_data,
        input  locked,
        input  mismatch,
        input  err_count
    );

    modport slave (
        input  seed,
        input  in_valid,
        input  in_data,
        output locked,
        output mismatch,
        output err_count
    );
endinterface

// File: rtl/lfsr_3bits_checker.sv
// Receive-side checker for the 3-bit XNOR LFSR generator. It predicts each
// next sample, locks onto the stream after a run of correct predictions,
// and pulses/counts mispredictions while locked.
module lfsr_3bits_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int MAX_ERRORS = 2,
    parameter int COUNT_W    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    lfsr_3bits_checker_if.slave  bus
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int ERR_W = $clog2(MAX_ERRORS + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2:0]         prev;
    logic [RUN_W-1:0]   run;
    logic [ERR_W-1:0]   err_run;
    logic               mismatch_q;
    logic [COUNT_W-1:0] err_count_q;

    logic [2:0]         pred;
    logic               match;
    logic [RUN_W-1:0]   run_inc;
    logic [ERR_W-1:0]   err_inc;
    logic               run_done;
    logic               err_done;

    // Next generator value; 111 is never produced by stepping, only by reload from seed.
    function automatic logic [2:0] predict(input logic [2:0] p, input logic [2:0] s);
        if (p == 3'b111) begin
            return s;
        end
        return {p[1:0], ~(p[2] ^ p[1])};
    endfunction

    assign pred     = predict(prev, bus.seed);
    assign match    = (bus.in_data == pred);
    assign run_inc  = run + RUN_W'(1);
    assign err_inc  = err_run + ERR_W'(1);
    assign run_done = (run_inc == RUN_W'(LOCK_COUNT));
    assign err_done = (err_inc == ERR_W'(MAX_ERRORS));

    // State register for the acquisition FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; only valid samples move the FSM.
    always_comb begin
        state_next = state;
        if (bus.in_valid) begin
            case (state)
                HUNT:    state_next = ACQUIRE;
                ACQUIRE: if (match && run_done) state_next = LOCKED;
                LOCKED:  if (!match && err_done) state_next = ACQUIRE;
                default: state_next = HUNT;
            endcase
        end
    end

    // Prediction history, run counters and error reporting; LOCKED flywheels on its own prediction.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev        <= 3'b000;
            run         <= '0;
            err_run     <= '0;
            mismatch_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            mismatch_q <= 1'b0;
            if (bus.in_valid) begin
                case (state)
                    HUNT: begin
                        prev <= bus.in_data;
                        run  <= '0;
                    end
                    ACQUIRE: begin
                        prev <= bus.in_data;
                        if (match) begin
                            run <= run_inc;
                            if (run_done) begin
                                err_run <= '0;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        prev <= pred;
                        if (match) begin
                            err_run <= '0;
                        end else begin
                            mismatch_q <= 1'b1;
                            err_run    <= err_inc;
                            if (err_count_q != {COUNT_W{1'b1}}) begin
                                err_count_q <= err_count_q + COUNT_W'(1);
                            end
                            if (err_done) begin
                                prev <= bus.in_data;
                                run  <= '0;
                            end
                        end
                    end
                    default: begin
                        prev <= 3'b000;
                        run  <= '0;
                    end
                endcase
            end
        end
    end

    // Status outputs, all taken straight from registers.
    always_comb begin
        bus.locked    = (state == LOCKED);
        bus.mismatch  = mismatch_q;
        bus.err_count = err_count_q;
    end

endmodule

// File: tb/tb_lfsr_3bits_checker.sv
// Directed bench for the LFSR stream checker: acquisition, corrupt samples,
// re-acquire, valid gaps, the 111 seed case, reset while locked and counter saturation.
module tb_lfsr_3bits_checker;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    lfsr_3bits_checker_if #(.COUNT_W(8)) bus ();

    lfsr_3bits_checker #(
        .LOCK_COUNT(3),
        .MAX_ERRORS(2),
        .COUNT_W(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Present one input cycle, then sample outputs 1 unit after the edge.
    task automatic send(input logic valid, input logic [2:0] data);
        bus.in_valid = valid;
        bus.in_data  = data;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string name, input logic lk, input logic mm, input logic [7:0] ec);
        checks++;
        if (bus.locked !== lk || bus.mismatch !== mm || bus.err_count !== ec) begin
            errors++;
            $display("[TB] FAIL %s: got locked=%b mismatch=%b err_count=%0d, expected locked=%b mismatch=%b err_count=%0d",
                     name, bus.locked, bus.mismatch, bus.err_count, lk, mm, ec);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        send(1'b1, 3'b000);
        send(1'b1, 3'b000);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        expect_out("reset_state", 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_acquire();
        bus.seed = 3'b010;
        send(1'b1, 3'b010); expect_out("acq_s1", 1'b0, 1'b0, 8'd0);
        send(1'b1, 3'b100); expect_out("acq_s2", 1'b0, 1'b0, 8'd0);
        send(1'b1, 3'b000); expect_out("acq_s3", 1'b0, 1'b0, 8'd0);
        send(1'b1, 3'b001); expect_out("acq_lock", 1'b1, 1'b0, 8'd0);
    endtask

    task automatic test_single_corrupt();
        send(1'b1, 3'b011); expect_out("corrupt_pre", 1'b1, 1'b0, 8'd0);
        send(1'b1, 3'b111); expect_out("corrupt_hit", 1'b1, 1'b1, 8'd1);
        send(1'b1, 3'b101); expect_out("corrupt_flywheel1", 1'b1, 1'b0, 8'd1);
        send(1'b1, 3'b010); expect_out("corrupt_flywheel2", 1'b1, 1'b0, 8'd1);
    endtask

    task automatic test_double_error();
        send(1'b1, 3'b100); expect_out("dbl_good1", 1'b1, 1'b0, 8'd1);
        send(1'b1, 3'b000); expect_out("dbl_good2", 1'b1, 1'b0, 8'd1);
        send(1'b1, 3'b001); expect_out("dbl_good3", 1'b1, 1'b0, 8'd1);
        send(1'b1, 3'b000); expect_out("dbl_bad1", 1'b1, 1'b1, 8'd2);
        send(1'b1, 3'b000); expect_out("dbl_bad2_unlock", 1'b0, 1'b1, 8'd3);
        send(1'b1, 3'b001); expect_out("relock1", 1'b0, 1'b0, 8'd3);
        send(1'b1, 3'b011); expect_out("relock2", 1'b0, 1'b0, 8'd3);
        send(1'b1, 3'b110); expect_out("relock3", 1'b1, 1'b0, 8'd3);
    endtask

    task automatic test_valid_gap();
        for (int i = 0; i < 10; i++) begin
            send(1'b0, 3'b111);
            expect_out($sformatf("gap_%0d", i), 1'b1, 1'b0, 8'd3);
        end
        send(1'b1, 3'b101); expect_out("gap_resume1", 1'b1, 1'b0, 8'd3);
        send(1'b1, 3'b010); expect_out("gap_resume2", 1'b1, 1'b0, 8'd3);
    endtask

    task automatic test_seed_111();
        do_reset();
        bus.seed = 3'b111;
        send(1'b1, 3'b111); expect_out("s111_1", 1'b0, 1'b0, 8'd0);
        send(1'b1, 3'b111); expect_out("s111_2", 1'b0, 1'b0, 8'd0);
        send(1'b1, 3'b111); expect_out("s111_3", 1'b0, 1'b0, 8'd0);
        send(1'b1, 3'b111); expect_out("s111_lock", 1'b1, 1'b0, 8'd0);
        bus.seed = 3'b010;
        send(1'b1, 3'b010); expect_out("seed_change", 1'b1, 1'b0, 8'd0);
        send(1'b1, 3'b100); expect_out("seed_follow", 1'b1, 1'b0, 8'd0);
    endtask

    task automatic test_reset_locked();
        send(1'b1, 3'b111); expect_out("rl_bad", 1'b1, 1'b1, 8'd1);
        reset = 1'b1;
        send(1'b1, 3'b000); expect_out("rl_reset", 1'b0, 1'b0, 8'd0);
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        bus.seed = 3'b010;
        send(1'b1, 3'b000);
        for (int i = 0; i < 130; i++) begin
            send(1'b1, 3'b001);
            send(1'b1, 3'b011);
            send(1'b1, 3'b110);
            send(1'b1, 3'b000);
            send(1'b1, 3'b000);
            if (i == 126) begin
                expect_out("sat_254", 1'b0, 1'b1, 8'd254);
            end
        end
        expect_out("sat_255", 1'b0, 1'b1, 8'd255);
        send(1'b1, 3'b001);
        send(1'b1, 3'b011);
        send(1'b1, 3'b110); expect_out("sat_relock", 1'b1, 1'b0, 8'd255);
        send(1'b1, 3'b000); expect_out("sat_hold", 1'b1, 1'b1, 8'd255);
    endtask

    // Scenario sequence and summary.
    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.seed     = 3'b010;
        bus.in_valid = 1'b0;
        bus.in_data  = 3'b000;
        test_reset();
        test_acquire();
        test_single_corrupt();
        test_double_error();
        test_valid_gap();
        test_seed_111();
        test_reset_locked();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
